led_pwm_bank: RTL and testbench
===============================

Name: led_pwm_bank

Overview:
- Downstream consumer of the serial-in LED shift register.
- On the rising edge of the active-low frame enable `en`, it latches the parallel word just shifted in. The word carries a channel index and a duty value.
- It drives NUM_CH LED outputs with glitch-free PWM. Duty changes take effect only at PWM period boundaries.
- Runs on the same free-running clk as the shift register.

Parameters:
- CH_BITS, 3, width of channel-index field; NUM_CH = 2**CH_BITS.
- DUTY_BITS, 5, width of duty field; PWM period PER = 2**DUTY_BITS - 1 counts.
- W, 8, parallel word width; must equal CH_BITS + DUTY_BITS.
- PRESCALE, 1, clk cycles per PWM count (>=1).

Ports:
- clk  in  1  system clock, shared with shift register
- reset  in  1  synchronous, active-low
- en  in  1  frame enable, active-low, same net as shift register `en`
- word  in  W  parallel output of shift register
- led  out  NUM_CH  PWM LED drive, active-high
- frame_done  out  1  one-cycle pulse when a word is committed

Behaviour:
- Reset values, clocked when reset==0:
  - led=0, frame_done=0, shadow[]=0, active[]=0.
  - Prescaler=0, cnt=0, en_d=1, armed=0.
- Word format: ch = word[W-1:DUTY_BITS], duty = word[DUTY_BITS-1:0].
- Arming:
  - armed is set on any cycle where en is sampled high.
  - This prevents latching a partial word when reset releases mid-frame with en low.
- Commit: condition is en_d==0 && en==1 && armed, where en_d is en delayed by one clk.
  - On that edge: shadow[ch] <= duty.
  - frame_done=1 on the following cycle only.
  - All other shadow entries are unchanged.
- Timebase:
  - tick asserts when prescaler == PRESCALE-1. The prescaler then wraps to 0; otherwise it increments.
  - With PRESCALE=1, tick is asserted every cycle.
  - On tick: if cnt==PER-1, then cnt<=0 and active[]<=shadow[] for all channels (period boundary). Otherwise cnt<=cnt+1.
- Output:
  - led[i] <= (cnt < active[i]), registered, one cycle after cnt.
  - duty 0 gives constant off; duty PER (all ones) gives constant on; duty k gives k high counts per PER counts.
- Simultaneous commit and period boundary in the same cycle:
  - active copies the pre-commit shadow.
  - The new duty applies from the next boundary.
- Back-to-back frames to the same channel within one period: the last committed value wins.
- en held low indefinitely: no commit; PWM continues unaffected.
- Reset asserted mid-period or mid-frame: all state returns to reset values within that cycle. LEDs are off from the next cycle.

Decomposition:
- Shared package led_ctrl_pkg:
  - Constants CH_BITS, DUTY_BITS, W.
  - Derived NUM_CH and PER.
  - Field-extraction helpers for ch and duty.
- Sub-module pwm_timebase: prescaler plus cnt counter.
  - Outputs cnt and a period_end strobe (tick && cnt==PER-1).
  - Reused by future LED effect blocks.
- Shadow/active register arrays, edge detect and compare stay in led_pwm_bank.

Test Plan:
- Reset then idle with en=1 for 100 cycles -> led==0, frame_done never asserts.
- word=8'b010_10000 (ch2, duty16), pulse en low 8 cycles then high -> frame_done one cycle later. After the next period boundary, led[2] is high 16 of every 31 cycles; other leds stay 0.
- ch5 duty 0, then ch5 duty 31 -> led[5] constant 0, then constant 1 from the boundary following the second commit, with no partial-period glitch.
- Commit ch1 duty 8 on the exact cycle cnt==30 with tick -> that period's boundary still loads the old value 0. led[1] first goes high one full period later.
- Hold en low, assert reset, release reset with en still low, then raise en -> no commit, no frame_done. The next full en low/high frame commits normally.
- PRESCALE=4, ch0 duty 1 -> led[0] high for exactly 4 clk cycles per 124-cycle period.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// Shared constants and word-field helpers for the LED control blocks.
// The parallel word is {channel index, duty}; PWM period is 2**DUTY_BITS-1 counts.
package led_ctrl_pkg;

    localparam int CH_BITS   = 3;
    localparam int DUTY_BITS = 5;
    localparam int W         = CH_BITS + DUTY_BITS;
    localparam int NUM_CH    = 2 ** CH_BITS;
    localparam int PER       = 2 ** DUTY_BITS - 1;

    function automatic logic [CH_BITS-1:0] word_ch(input logic [W-1:0] w);
        return w[W-1:DUTY_BITS];
    endfunction

    function automatic logic [DUTY_BITS-1:0] word_duty(input logic [W-1:0] w);
        return w[DUTY_BITS-1:0];
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: prescaler dividing clk into counts, and a count that wraps
// after 2**CNT_BITS-1 counts, with a strobe on the last count of each period.
module pwm_timebase #(
    parameter int CNT_BITS = 5,
    parameter int PRESCALE = 1
) (
    input  logic                clk,
    input  logic                reset,
    output logic [CNT_BITS-1:0] cnt,
    output logic                period_end
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(2 ** CNT_BITS - 2);

    logic [PS_W-1:0] ps;
    logic            tick;

    assign tick       = (ps == PS_W'(PRESCALE - 1));
    assign period_end = tick && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            ps  <= '0;
            cnt <= '0;
        end else begin
            if (tick) ps <= '0;
            else      ps <= ps + 1'b1;

            if (period_end) cnt <= '0;
            else if (tick)  cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_pwm_bank.sv
// Latches {ch, duty} words from the LED shift register on the rising edge of
// the active-low frame enable and drives glitch-free PWM on NUM_CH outputs.
module led_pwm_bank #(
    parameter int CH_BITS   = led_ctrl_pkg::CH_BITS,
    parameter int DUTY_BITS = led_ctrl_pkg::DUTY_BITS,
    parameter int W         = led_ctrl_pkg::W,
    parameter int PRESCALE  = 1,
    localparam int NUM_CH   = 2 ** CH_BITS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [W-1:0]      word,
    output logic [NUM_CH-1:0] led,
    output logic              frame_done
);

    generate
        if (W != CH_BITS + DUTY_BITS) begin : g_bad_width
            $error("led_pwm_bank: W must equal CH_BITS + DUTY_BITS");
        end
    endgenerate

    logic [CH_BITS-1:0]                 ch;
    logic [DUTY_BITS-1:0]               duty;
    logic [DUTY_BITS-1:0]               cnt;
    logic                               period_end;
    logic                               en_d;
    logic                               armed;
    logic                               commit;
    logic [NUM_CH-1:0][DUTY_BITS-1:0]   shadow;
    logic [NUM_CH-1:0][DUTY_BITS-1:0]   active;

    assign ch   = word[W-1:DUTY_BITS];
    assign duty = word[DUTY_BITS-1:0];

    // armed blocks a commit when reset releases in the middle of a frame
    assign commit = !en_d && en && armed;

    pwm_timebase #(
        .CNT_BITS (DUTY_BITS),
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .clk        (clk),
        .reset      (reset),
        .cnt        (cnt),
        .period_end (period_end)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            en_d       <= 1'b1;
            armed      <= 1'b0;
            frame_done <= 1'b0;
            shadow     <= '0;
            active     <= '0;
            led        <= '0;
        end else begin
            en_d       <= en;
            frame_done <= commit;
            if (en)         armed       <= 1'b1;
            if (commit)     shadow[ch]  <= duty;
            // a same-cycle commit is not visible here: active takes the old shadow
            if (period_end) active      <= shadow;
            for (int i = 0; i < NUM_CH; i++)
                led[i] <= (cnt < active[i]);
        end
    end

endmodule

// File: tb/tb_led_pwm_bank.sv
// Directed bench for led_pwm_bank: PRESCALE=1 instance for the main scenarios
// and a PRESCALE=4 instance for the prescaled timebase.
module tb_led_pwm_bank;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b1;
    logic       en4 = 1'b1;
    logic [7:0] word = 8'h00;
    logic [7:0] word4 = 8'h00;
    logic [7:0] led;
    logic [7:0] led4;
    logic       frame_done;
    logic       frame_done4;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    // posedges since reset release; cnt of the PRESCALE=1 DUT is cyc % 31
    always @(posedge clk) cyc <= reset ? cyc + 1 : 0;

    led_pwm_bank #(.PRESCALE(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .word       (word),
        .led        (led),
        .frame_done (frame_done)
    );

    led_pwm_bank #(.PRESCALE(4)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .en         (en4),
        .word       (word4),
        .led        (led4),
        .frame_done (frame_done4)
    );

    task automatic frame(input logic [2:0] ch, input logic [4:0] duty, input int low);
        word = {ch, duty};
        en = 1'b0;
        repeat (low) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL frame_done_pulse ch%0d: got %b want 1", ch, frame_done);
        end
    endtask

    task automatic test_reset();
        int led_bad = 0, fd_bad = 0;
        reset = 1'b0;
        en = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (led !== 8'h00) begin
            errors++; $display("FAIL reset_led: got %h want 00", led);
        end
        checks++;
        if (frame_done !== 1'b0) begin
            errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done);
        end
        reset = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (led !== 8'h00) led_bad++;
            if (frame_done !== 1'b0) fd_bad++;
        end
        checks++;
        if (led_bad != 0) begin
            errors++; $display("FAIL idle_led: %0d nonzero samples, want 0", led_bad);
        end
        checks++;
        if (fd_bad != 0) begin
            errors++; $display("FAIL idle_frame_done: %0d pulses, want 0", fd_bad);
        end
    endtask

    task automatic test_single_channel();
        int highs = 0, others = 0;
        frame(3'd2, 5'd16, 8);
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0) begin
            errors++; $display("FAIL frame_done_width: got %b want 0", frame_done);
        end
        repeat (70) @(negedge clk);
        for (int k = 0; k < 31; k++) begin
            @(negedge clk);
            if (led[2] === 1'b1) highs++;
            if ((led & 8'hFB) !== 8'h00) others++;
        end
        checks++;
        if (highs != 16) begin
            errors++; $display("FAIL ch2_duty16: got %0d high of 31, want 16", highs);
        end
        checks++;
        if (others != 0) begin
            errors++; $display("FAIL ch2_others: got %0d bad samples, want 0", others);
        end
    endtask

    task automatic test_full_range();
        int highs = 0, bad = 0;
        logic loaded = 1'b0;
        int pre;
        frame(3'd5, 5'd0, 4);
        repeat (70) @(negedge clk);
        for (int k = 0; k < 31; k++) begin
            @(negedge clk);
            if (led[5] !== 1'b0) highs++;
        end
        checks++;
        if (highs != 0) begin
            errors++; $display("FAIL ch5_duty0: got %0d high of 31, want 0", highs);
        end
        frame(3'd5, 5'd31, 4);
        for (int k = 0; k < 70; k++) begin
            pre = cyc % 31;
            @(negedge clk);
            if (led[5] !== loaded) bad++;
            if (pre == 30) loaded = 1'b1;
        end
        checks++;
        if (bad != 0 || !loaded) begin
            errors++; $display("FAIL ch5_duty31_switch: got %0d bad samples (loaded=%b), want 0", bad, loaded);
        end
    endtask

    task automatic test_boundary_commit();
        int bad = 0;
        logic exp;
        word = {3'd1, 5'd8};
        en = 1'b0;
        repeat (2) @(negedge clk);
        while (cyc % 31 != 30) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b1 || led[1] !== 1'b0) begin
            errors++; $display("FAIL boundary_commit: got frame_done=%b led1=%b want 1,0", frame_done, led[1]);
        end
        for (int k = 1; k <= 62; k++) begin
            @(negedge clk);
            exp = (k >= 32 && k <= 39);
            if (led[1] !== exp) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL boundary_deferred: got %0d bad led1 samples, want 0", bad);
        end
    endtask

    task automatic test_reset_midframe();
        int fd = 0, nz = 0, highs = 0, others = 0;
        word = {3'd3, 5'd31};
        en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (led !== 8'h00 || frame_done !== 1'b0) begin
            errors++; $display("FAIL midreset_clear: got led=%h fd=%b want 00,0", led, frame_done);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (frame_done !== 1'b0) fd++;
            if (led !== 8'h00) nz++;
        end
        checks++;
        if (fd != 0 || nz != 0) begin
            errors++; $display("FAIL midreset_no_commit: got %0d pulses %0d led samples, want 0,0", fd, nz);
        end
        frame(3'd3, 5'd31, 6);
        repeat (70) @(negedge clk);
        for (int k = 0; k < 31; k++) begin
            @(negedge clk);
            if (led[3] === 1'b1) highs++;
            if ((led & 8'hF7) !== 8'h00) others++;
        end
        checks++;
        if (highs != 31 || others != 0) begin
            errors++; $display("FAIL midreset_next_frame: got %0d high, %0d other, want 31,0", highs, others);
        end
    endtask

    task automatic test_prescale();
        logic s [124];
        int highs = 0, rises = 0, others = 0;
        word4 = {3'd0, 5'd1};
        en4 = 1'b0;
        repeat (4) @(negedge clk);
        en4 = 1'b1;
        @(negedge clk);
        checks++;
        if (frame_done4 !== 1'b1) begin
            errors++; $display("FAIL prescale_frame_done: got %b want 1", frame_done4);
        end
        repeat (260) @(negedge clk);
        for (int k = 0; k < 124; k++) begin
            @(negedge clk);
            s[k] = led4[0];
            if (led4[0] === 1'b1) highs++;
            if ((led4 & 8'hFE) !== 8'h00) others++;
        end
        for (int k = 0; k < 124; k++)
            if (s[k] === 1'b1 && s[(k + 123) % 124] === 1'b0) rises++;
        checks++;
        if (highs != 4 || rises != 1) begin
            errors++; $display("FAIL prescale_duty1: got %0d high %0d pulses, want 4,1", highs, rises);
        end
        checks++;
        if (others != 0) begin
            errors++; $display("FAIL prescale_others: got %0d bad samples, want 0", others);
        end
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_full_range();
        test_boundary_commit();
        test_reset_midframe();
        test_prescale();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
